// File: rtl/vector_list_reader.sv
// Vector display list reader: fetches one frame's words from synchronous memory
// and emits MOVE/LINE commands to the line drawer through a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for frame_start
// REQ    | one-cycle read strobe at addr
// WAIT   | counting memory latency, captures mem_data
// DECODE | acts on the captured word
// HOLD   | presenting a command until cmd_ready
module vector_list_reader #(
  parameter int ADDRESSWIDTH = 16,
  parameter int DATAWIDTH    = 18,
  parameter int OUT_WIDTH    = 8,
  parameter int BASE_ADDR    = 0,
  parameter int MEM_LATENCY  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  output logic                    mem_rd,
  output logic [ADDRESSWIDTH-1:0] mem_addr,
  input  logic [DATAWIDTH-1:0]    mem_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    cmd_draw,
  output logic [OUT_WIDTH-1:0]    cmd_x,
  output logic [OUT_WIDTH-1:0]    cmd_y,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overflow,
  output logic [ADDRESSWIDTH-1:0] vec_count
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DECODE, S_HOLD} state_t;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_LINE = 2'b01;
  localparam logic [1:0] OP_END  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;
  localparam logic [ADDRESSWIDTH-1:0] BASE = ADDRESSWIDTH'(BASE_ADDR);
  localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);

  state_t                  state, state_nxt;
  logic [ADDRESSWIDTH-1:0] addr;
  logic [DATAWIDTH-1:0]    word;
  logic [1:0]              lat_cnt;
  logic                    pending;
  logic [1:0]              opcode;
  logic                    at_last;

  logic load_frame, addr_inc, lat_load, word_load, cmd_load, vec_inc, set_ovf, finish;

  assign opcode    = word[DATAWIDTH-1 -: 2];
  assign at_last   = (addr == '1);
  assign cmd_valid = (state == S_HOLD);
  assign busy      = (state != S_IDLE);
  assign mem_addr  = (state == S_REQ) ? addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_rd     = 1'b0;
    frame_done = 1'b0;
    load_frame = 1'b0;
    addr_inc   = 1'b0;
    lat_load   = 1'b0;
    word_load  = 1'b0;
    cmd_load   = 1'b0;
    vec_inc    = 1'b0;
    set_ovf    = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          load_frame = 1'b1;
          state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        mem_rd    = 1'b1;
        lat_load  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == 2'd0) begin
          word_load = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_END: finish = 1'b1;
          OP_NOP: begin
            if (at_last) begin
              set_ovf = 1'b1;
              finish  = 1'b1;
            end else begin
              addr_inc  = 1'b1;
              state_nxt = S_REQ;
            end
          end
          default: begin
            cmd_load  = 1'b1;
            state_nxt = S_HOLD;
          end
        endcase
      end
      S_HOLD: begin
        if (cmd_ready) begin
          vec_inc = 1'b1;
          if (at_last) begin
            set_ovf = 1'b1;
            finish  = 1'b1;
          end else begin
            addr_inc  = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A start request seen during the frame (or on its last cycle) restarts without idling.
    if (finish) begin
      frame_done = 1'b1;
      if (pending || frame_start) begin
        load_frame = 1'b1;
        state_nxt  = S_REQ;
      end else begin
        state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= BASE;
      vec_count <= '0;
      pending   <= 1'b0;
      lat_cnt   <= 2'd0;
      word      <= '0;
      cmd_draw  <= 1'b0;
      cmd_x     <= '0;
      cmd_y     <= '0;
      overflow  <= 1'b0;
    end else begin
      if (load_frame) begin
        addr      <= BASE;
        vec_count <= '0;
        pending   <= 1'b0;
      end else begin
        if (addr_inc) addr <= addr + 1'b1;
        if (vec_inc && (vec_count != '1)) vec_count <= vec_count + 1'b1;
        if (frame_start && (state != S_IDLE)) pending <= 1'b1;
      end
      if (lat_load)
        lat_cnt <= LAT_INIT;
      else if ((state == S_WAIT) && (lat_cnt != 2'd0))
        lat_cnt <= lat_cnt - 1'b1;
      if (word_load) word <= mem_data;
      if (cmd_load) begin
        cmd_draw <= (opcode == OP_LINE);
        cmd_x    <= word[2*OUT_WIDTH-1:OUT_WIDTH];
        cmd_y    <= word[OUT_WIDTH-1:0];
      end
      if (set_ovf) overflow <= 1'b1;
    end
  end

endmodule
